fee_row_group_ctrl: RTL and testbench

FEE_ROW_GROUP_CTRL -- requirements
Module: fee_row_group_ctrl

---
 rtl/fee_row_pkg.sv | 23 ++
 rtl/fee_rst_group_fsm.sv | 84 ++++++++
 rtl/fee_row_group_ctrl.sv | 71 +++++++
 tb/tb_fee_row_group_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/fee_row_pkg.sv
// Shared types and default constants for the front-end row-group reset controller.
package fee_row_pkg;

  localparam int unsigned DEF_NUM_ROWS        = 20;
  localparam int unsigned DEF_ROWS_PER_GROUP  = 4;
  localparam int unsigned DEF_RST_MIN_CYCLES  = 16;
  localparam int unsigned DEF_RECOVERY_CYCLES = 8;

  typedef enum logic [1:0] {
    ASSERT  = 2'd0,
    RECOVER = 2'd1,
    IDLE    = 2'd2
  } grp_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/fee_rst_group_fsm.sv
// One row group's reset sequencer: hold reset low, let the rows settle, then go idle.
module fee_rst_group_fsm
  import fee_row_pkg::*;
#(
  parameter int unsigned RST_MIN_CYCLES  = DEF_RST_MIN_CYCLES,
  parameter int unsigned RECOVERY_CYCLES = DEF_RECOVERY_CYCLES
) (
  input  logic sysclk,
  input  logic rst,
  input  logic req,
  output logic resn,
  output logic busy
);

  localparam int unsigned CNT_W = $clog2(max_u(RST_MIN_CYCLES, RECOVERY_CYCLES) + 1);
  localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'(RST_MIN_CYCLES);
  localparam logic [CNT_W-1:0] REC_LOAD = CNT_W'(RECOVERY_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  grp_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             resn_q, resn_d;
  logic             busy_q, busy_d;

  // Reset leaves the group mid power-on sequence with a full low window pending.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state_q <= ASSERT;
      cnt_q   <= RST_LOAD;
      resn_q  <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      resn_q  <= resn_d;
      busy_q  <= busy_d;
    end
  end

  // Expiry is taken at a count of one so the loaded value equals the cycles spent.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ASSERT: begin
        if (req) begin
          cnt_d = RST_LOAD;
        end else if (cnt_q <= CNT_ONE) begin
          state_d = RECOVER;
          cnt_d   = REC_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      RECOVER: begin
        if (req) begin
          state_d = ASSERT;
          cnt_d   = RST_LOAD;
        end else if (cnt_q <= CNT_ONE) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      IDLE: begin
        if (req) begin
          state_d = ASSERT;
          cnt_d   = RST_LOAD;
        end
      end
      default: begin
        state_d = ASSERT;
        cnt_d   = RST_LOAD;
      end
    endcase
    resn_d = (state_d != ASSERT);
    busy_d = (state_d != IDLE);
  end

  assign resn = resn_q;
  assign busy = busy_q;

endmodule

// File: rtl/fee_row_group_ctrl.sv
// Row-group reset controller with per-row interrupt synchronisers.
// Define FEE_INT_MASK_EN to suppress a row's interrupt while its group is busy.
module fee_row_group_ctrl
  import fee_row_pkg::*;
#(
  parameter int unsigned NUM_ROWS        = DEF_NUM_ROWS,
  parameter int unsigned ROWS_PER_GROUP  = DEF_ROWS_PER_GROUP,
  parameter int unsigned RST_MIN_CYCLES  = DEF_RST_MIN_CYCLES,
  parameter int unsigned RECOVERY_CYCLES = DEF_RECOVERY_CYCLES,
  localparam int unsigned NUM_GROUPS     = (NUM_ROWS + ROWS_PER_GROUP - 1) / ROWS_PER_GROUP
) (
  input  logic                  sysclk,
  input  logic                  rst,
  input  logic [NUM_ROWS-1:0]   row_rst_req,
  input  logic [NUM_GROUPS-1:0] grp_force_rst,
  input  logic [NUM_ROWS-1:0]   row_int_n,
  output logic [NUM_GROUPS-1:0] group_resn,
  output logic [NUM_GROUPS-1:0] group_busy,
  output logic [NUM_ROWS-1:0]   row_int_n_sync
);

  logic [NUM_GROUPS-1:0] grp_req_c;

  // The last group only spans the rows that actually exist.
  for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_grp
    localparam int unsigned LO = g * ROWS_PER_GROUP;
    localparam int unsigned HI = min_u((g + 1) * ROWS_PER_GROUP, NUM_ROWS) - 1;

    assign grp_req_c[g] = grp_force_rst[g] | (|row_rst_req[HI:LO]);

    fee_rst_group_fsm #(
      .RST_MIN_CYCLES  (RST_MIN_CYCLES),
      .RECOVERY_CYCLES (RECOVERY_CYCLES)
    ) u_fsm (
      .sysclk (sysclk),
      .rst    (rst),
      .req    (grp_req_c[g]),
      .resn   (group_resn[g]),
      .busy   (group_busy[g])
    );
  end

  logic [NUM_ROWS-1:0] sync1_q, sync1_d;
  logic [NUM_ROWS-1:0] sync2_q, sync2_d;

  always_comb begin
    sync1_d = row_int_n;
    sync2_d = sync1_q;
  end

  // Synchroniser idles at the inactive (high) interrupt level.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

`ifdef FEE_INT_MASK_EN
  for (genvar r = 0; r < NUM_ROWS; r++) begin : g_mask
    localparam int unsigned GRP = r / ROWS_PER_GROUP;
    assign row_int_n_sync[r] = sync2_q[r] | group_busy[GRP];
  end
`else
  assign row_int_n_sync = sync2_q;
`endif

endmodule

// File: tb/tb_fee_row_group_ctrl.sv
// Randomised bench for fee_row_group_ctrl against a remaining-time reference model.
module tb_fee_row_group_ctrl;

  localparam int A_ROWS = 20, A_RPG = 4, A_GRPS = 5, A_RST = 16, A_REC = 8;
  localparam int B_ROWS = 10, B_RPG = 4, B_GRPS = 3, B_RST = 3,  B_REC = 2;

`ifdef FEE_INT_MASK_EN
  localparam bit MASK_EN = 1'b1;
`else
  localparam bit MASK_EN = 1'b0;
`endif

  logic sysclk = 1'b0;
  logic rst;
  logic [A_ROWS-1:0] rr_a, iv_a, sync_a;
  logic [A_GRPS-1:0] fr_a, resn_a, busy_a;
  logic [B_ROWS-1:0] rr_b, iv_b, sync_b;
  logic [B_GRPS-1:0] fr_b, resn_b, busy_b;

  always #5 sysclk = ~sysclk;

  fee_row_group_ctrl #(
    .NUM_ROWS(A_ROWS), .ROWS_PER_GROUP(A_RPG), .RST_MIN_CYCLES(A_RST), .RECOVERY_CYCLES(A_REC)
  ) u_dut_a (
    .sysclk(sysclk), .rst(rst), .row_rst_req(rr_a), .grp_force_rst(fr_a), .row_int_n(iv_a),
    .group_resn(resn_a), .group_busy(busy_a), .row_int_n_sync(sync_a)
  );

  fee_row_group_ctrl #(
    .NUM_ROWS(B_ROWS), .ROWS_PER_GROUP(B_RPG), .RST_MIN_CYCLES(B_RST), .RECOVERY_CYCLES(B_REC)
  ) u_dut_b (
    .sysclk(sysclk), .rst(rst), .row_rst_req(rr_b), .grp_force_rst(fr_b), .row_int_n(iv_b),
    .group_resn(resn_b), .group_busy(busy_b), .row_int_n_sync(sync_b)
  );

  int total = 0;
  int bad   = 0;

  // Model: cycles of reset-low and of busy still owed per group, plus interrupt history.
  int low_a[A_GRPS], bsy_a[A_GRPS], low_b[B_GRPS], bsy_b[B_GRPS];
  logic [A_ROWS-1:0] h1_a, h2_a;
  logic [B_ROWS-1:0] h1_b, h2_b;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s @%0t got=%h exp=%h", tag, $time, got, exp);
    end
  endtask

  function automatic void grp_step(input bit req, input int rl, input int cl,
                                   inout int low, inout int bsy);
    if (req) begin
      low = rl;
      bsy = rl + cl;
    end else begin
      if (low > 0) low--;
      if (bsy > 0) bsy--;
    end
  endfunction

  function automatic void model_reset();
    for (int g = 0; g < A_GRPS; g++) begin low_a[g] = A_RST; bsy_a[g] = A_RST + A_REC; end
    for (int g = 0; g < B_GRPS; g++) begin low_b[g] = B_RST; bsy_b[g] = B_RST + B_REC; end
    h1_a = '1; h2_a = '1; h1_b = '1; h2_b = '1;
  endfunction

  // Predicts the state after the coming rising edge from the inputs now applied.
  function automatic void model_update();
    bit qa[A_GRPS];
    bit qb[B_GRPS];
    if (rst) begin
      model_reset();
      return;
    end
    for (int g = 0; g < A_GRPS; g++) qa[g] = fr_a[g];
    for (int g = 0; g < B_GRPS; g++) qb[g] = fr_b[g];
    for (int r = 0; r < A_ROWS; r++) if (rr_a[r]) qa[r / A_RPG] = 1'b1;
    for (int r = 0; r < B_ROWS; r++) if (rr_b[r]) qb[r / B_RPG] = 1'b1;
    for (int g = 0; g < A_GRPS; g++) grp_step(qa[g], A_RST, A_REC, low_a[g], bsy_a[g]);
    for (int g = 0; g < B_GRPS; g++) grp_step(qb[g], B_RST, B_REC, low_b[g], bsy_b[g]);
    h2_a = h1_a; h1_a = iv_a;
    h2_b = h1_b; h1_b = iv_b;
  endfunction

  task automatic compare_all();
    logic [A_GRPS-1:0] er_a, eb_a;
    logic [B_GRPS-1:0] er_b, eb_b;
    logic [A_ROWS-1:0] es_a;
    logic [B_ROWS-1:0] es_b;
    for (int g = 0; g < A_GRPS; g++) begin er_a[g] = (low_a[g] == 0); eb_a[g] = (bsy_a[g] > 0); end
    for (int g = 0; g < B_GRPS; g++) begin er_b[g] = (low_b[g] == 0); eb_b[g] = (bsy_b[g] > 0); end
    for (int r = 0; r < A_ROWS; r++) es_a[r] = h2_a[r] | (MASK_EN & eb_a[r / A_RPG]);
    for (int r = 0; r < B_ROWS; r++) es_b[r] = h2_b[r] | (MASK_EN & eb_b[r / B_RPG]);
    chk("resn_a", 32'(resn_a), 32'(er_a));
    chk("busy_a", 32'(busy_a), 32'(eb_a));
    chk("sync_a", 32'(sync_a), 32'(es_a));
    chk("resn_b", 32'(resn_b), 32'(er_b));
    chk("busy_b", 32'(busy_b), 32'(eb_b));
    chk("sync_b", 32'(sync_b), 32'(es_b));
  endtask

  task automatic tick();
    model_update();
    @(posedge sysclk);
    @(negedge sysclk);
    compare_all();
  endtask

  task automatic idle(input int n);
    rr_a = '0; fr_a = '0; rr_b = '0; fr_b = '0;
    repeat (n) tick();
  endtask

  // Asserts rst between edges and checks the outputs fall back before any clock.
  task automatic async_reset();
    #2 rst = 1'b1;
    #1 model_reset();
    compare_all();
    rr_a = '0; fr_a = '0; rr_b = '0; fr_b = '0;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    rr_a = '0; fr_a = '0; iv_a = '1;
    rr_b = '0; fr_b = '0; iv_b = '1;
    @(negedge sysclk);
    model_reset();
    compare_all();
    repeat (2) tick();
    rst = 1'b0;

    // Power-on sequence runs to idle on its own.
    idle(30);

    // Single-cycle row request into group 1; row 9 of the small instance hits its partial group.
    rr_a[5] = 1'b1; rr_b[9] = 1'b1;
    tick();
    idle(30);

    // Held request stretches the low window.
    rr_a[0] = 1'b1;
    repeat (10) tick();
    idle(30);

    // Software force, then a second force during recovery.
    fr_a[2] = 1'b1; fr_b[1] = 1'b1;
    tick();
    idle(19);
    fr_a[2] = 1'b1;
    tick();
    idle(30);

    // Interrupt on row 1 while group 0 is busy, held until after it goes idle.
    iv_a[1] = 1'b0; iv_b[1] = 1'b0;
    rr_a[0] = 1'b1; rr_b[0] = 1'b1;
    tick();
    idle(30);
    iv_a = '1; iv_b = '1;
    idle(3);

    // Several groups requested together.
    rr_a = 20'h8_4211; fr_b = 3'b111;
    tick();
    idle(30);

    for (int c = 0; c < 1500; c++) begin
      for (int r = 0; r < A_ROWS; r++) begin
        rr_a[r] = ($urandom_range(0, 399) == 0);
        if ($urandom_range(0, 7) == 0) iv_a[r] = ~iv_a[r];
      end
      for (int r = 0; r < B_ROWS; r++) begin
        rr_b[r] = ($urandom_range(0, 199) == 0);
        if ($urandom_range(0, 7) == 0) iv_b[r] = ~iv_b[r];
      end
      for (int g = 0; g < A_GRPS; g++) fr_a[g] = ($urandom_range(0, 299) == 0);
      for (int g = 0; g < B_GRPS; g++) fr_b[g] = ($urandom_range(0, 99) == 0);
      if (c == 700 || c == 1210) async_reset();
      else tick();
    end
    idle(30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
